// File: rtl/touch_key_debounce.sv
// rtl/touch_key_debounce.sv - touch pad synchroniser and press/release debouncer
// Optional long-press pulse on long_flag when LONG_PRESS_EN is defined.
module touch_key_debounce #(
  parameter int unsigned CNT_MAX      = 999_999,
  parameter int unsigned LONG_CNT_MAX = 49_999_999,
  parameter logic        KEY_ACTIVE   = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic touch_key,
  output logic key_flag,
  output logic key_state,
  output logic long_flag
);

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          sync1;
  logic          sync2;
  logic          key_act;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          key_flag_next;
  logic          key_state_next;

  // Sync flops rest at the idle level so reset release never looks like a touch.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= ~KEY_ACTIVE;
      sync2 <= ~KEY_ACTIVE;
    end else begin
      sync1 <= touch_key;
      sync2 <= sync1;
    end
  end

  assign key_act = (sync2 == KEY_ACTIVE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    key_flag_next  = 1'b0;
    key_state_next = key_state;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (key_act) state_next = PRESS_DB;
      end
      PRESS_DB: begin
        if (!key_act) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_TOP) begin
          state_next     = PRESSED;
          cnt_next       = '0;
          key_flag_next  = 1'b1;
          key_state_next = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      PRESSED: begin
        key_state_next = 1'b1;
        cnt_next       = '0;
        if (!key_act) state_next = RELEASE_DB;
      end
      RELEASE_DB: begin
        // A return to active resumes the press silently; no second key_flag.
        if (key_act) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_TOP) begin
          state_next     = IDLE;
          cnt_next       = '0;
          key_state_next = 1'b0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next     = IDLE;
        cnt_next       = '0;
        key_state_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt       <= '0;
      key_flag  <= 1'b0;
      key_state <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      key_flag  <= key_flag_next;
      key_state <= key_state_next;
    end
  end

`ifdef LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CNT_MAX + 2);
  localparam logic [LW-1:0] LONG_TOP = LW'(LONG_CNT_MAX);
  localparam logic [LW-1:0] LONG_SAT = LW'(LONG_CNT_MAX + 1);

  logic [LW-1:0] long_cnt;

  // long_cnt parks at LONG_SAT after firing so a hold yields one long_flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      long_cnt  <= '0;
      long_flag <= 1'b0;
    end else begin
      long_flag <= 1'b0;
      case (state)
        PRESSED: begin
          if (long_cnt == LONG_TOP) begin
            long_cnt  <= LONG_SAT;
            long_flag <= 1'b1;
          end else if (long_cnt < LONG_TOP) begin
            long_cnt <= long_cnt + LW'(1);
          end
        end
        RELEASE_DB: long_cnt <= long_cnt;
        default:    long_cnt <= '0;
      endcase
    end
  end
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^LONG_CNT_MAX;
  assign long_flag       = 1'b0;
`endif

endmodule
